// File: rtl/fip_sqrt_iter.sv
// fip_sqrt_iter: restoring fixed-point square root producing one root bit per cycle.
// Define FIP_SQRT_ROUND_EN to round the result to nearest instead of truncating.
module fip_sqrt_iter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FRA_BITS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rad,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_root,
  output logic             o_neg
);

  localparam int unsigned NW = WIDTH + FRA_BITS;
  localparam int unsigned R  = NW / 2;
  localparam int unsigned RW = R + 2;
  localparam int unsigned CW = (R > 2) ? $clog2(R) : 1;

  if ((NW % 2) != 0) begin : g_bad_parity
    $error("fip_sqrt_iter: WIDTH+FRA_BITS must be even");
  end
  if (FRA_BITS >= WIDTH) begin : g_bad_fra
    $error("fip_sqrt_iter: FRA_BITS must be smaller than WIDTH");
  end
  if (WIDTH < 4) begin : g_bad_width
    $error("fip_sqrt_iter: WIDTH must be at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [RW-1:0]   r_q, r_d;
  logic [R-1:0]    q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_d, valid_d, neg_d;
  logic [WIDTH-1:0] root_d;

  logic [RW-1:0]   r_sh, trial, r_new;
  logic [R-1:0]    q_new;
  logic            ge;
  logic [WIDTH-1:0] res;

  // One restoring step: bring in the next two radicand bits and try to subtract.
  // r never exceeds 2q, so the two bits shifted out of r are always zero.
  always_comb begin
    r_sh  = RW'({r_q, n_q[NW-1 -: 2]});
    trial = {q_q, 2'b01};
    ge    = (r_sh >= trial);
    r_new = ge ? (r_sh - trial) : r_sh;
    q_new = {q_q[R-2:0], ge};
  end

`ifdef FIP_SQRT_ROUND_EN
  // Round to nearest: the true root exceeds q+0.5 exactly when remainder > q.
  logic [R:0] res_rnd;
  always_comb res_rnd = (R+1)'(q_new) + (R+1)'(r_new > RW'(q_new));
  assign res = WIDTH'(res_rnd);
`else
  assign res = WIDTH'(q_new);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    root_d  = o_root;
    neg_d   = o_neg;
    case (state_q)
      IDLE: begin
        if (i_valid && o_ready) begin
          n_d   = NW'(i_rad) << FRA_BITS;
          r_d   = '0;
          q_d   = '0;
          cnt_d = CW'(R - 1);
          if (i_rad[WIDTH-1]) begin
            state_d = DONE;
            neg_d   = 1'b1;
            root_d  = '0;
          end else begin
            state_d = RUN;
            neg_d   = 1'b0;
          end
        end
      end
      RUN: begin
        n_d   = n_q << 2;
        r_d   = r_new;
        q_d   = q_new;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          root_d  = res;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_root  <= '0;
      o_neg   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      o_ready <= ready_d;
      o_valid <= valid_d;
      o_root  <= root_d;
      o_neg   <= neg_d;
    end
  end

endmodule

// File: tb/tb_fip_sqrt_iter.sv
// tb_fip_sqrt_iter: directed table plus randomized checks of fip_sqrt_iter
// against an integer-search square-root model.
module tb_fip_sqrt_iter;

  localparam int unsigned W = 32;
  localparam int unsigned F = 16;
  localparam int unsigned R = (W + F) / 2;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_rad;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_root;
  logic         o_neg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  fip_sqrt_iter #(.WIDTH(W), .FRA_BITS(F)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_rad  (i_rad),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_root (o_root),
    .o_neg  (o_neg)
  );

  typedef struct packed {
    logic [W-1:0] rad;
    logic [W-1:0] root;
    logic         neg;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Largest q with q*q <= rad*2^F, found by binary search on plain integers.
  function automatic logic [W-1:0] ref_root(input logic [W-1:0] rad);
    longint unsigned n, lo, hi, mid;
    if (rad[W-1]) return '0;
    n  = 64'(rad) << F;
    lo = 0;
    hi = 64'd1 << R;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= n) lo = mid;
      else hi = mid;
    end
`ifdef FIP_SQRT_ROUND_EN
    if (n - lo * lo > lo) lo = lo + 1;
`endif
    return W'(lo);
  endfunction

  task automatic xact(input logic [W-1:0] rad, input logic [W-1:0] exp_root, input logic exp_neg,
                      input int hold, input bit early, input bit poke, input string tag);
    int n;
    int lat;
    bit stable;
    logic [W-1:0] held;
    n = 0;
    while (!o_ready && n < 100) begin
      step();
      n++;
    end
    chk({tag, " ready_before"}, W'(o_ready), W'(1));
    i_valid = 1'b1;
    i_rad   = rad;
    i_ready = early;
    step();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 2 * R) begin
      if (poke) begin
        i_valid = 1'($urandom);
        i_rad   = $urandom;
      end
      step();
      lat++;
    end
    i_valid = 1'b0;
    chk({tag, " latency"}, W'(lat), exp_neg ? W'(0) : W'(R));
    chk({tag, " valid"}, W'(o_valid), W'(1));
    chk({tag, " root"}, o_root, exp_root);
    chk({tag, " neg"}, W'(o_neg), W'(exp_neg));
    if (!early) begin
      stable = 1'b1;
      held   = o_root;
      for (int k = 0; k < hold; k++) begin
        step();
        if (!o_valid || o_root !== held || o_ready || o_neg !== exp_neg) stable = 1'b0;
      end
      if (hold > 0) chk({tag, " hold_stable"}, W'(stable), W'(1));
      i_ready = 1'b1;
    end
    step();
    i_ready = 1'b0;
    chk({tag, " valid_drop"}, W'(o_valid), W'(0));
    chk({tag, " ready_after"}, W'(o_ready), W'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rad;
    bit seen;
    tbl[0] = '{rad: 32'h0004_0000, root: 32'h0002_0000, neg: 1'b0};
`ifdef FIP_SQRT_ROUND_EN
    tbl[1] = '{rad: 32'h0002_0000, root: 32'h0001_6A0A, neg: 1'b0};
`else
    tbl[1] = '{rad: 32'h0002_0000, root: 32'h0001_6A09, neg: 1'b0};
`endif
    tbl[2] = '{rad: 32'h7FFF_FFFF, root: 32'h00B5_04F3, neg: 1'b0};
    tbl[3] = '{rad: 32'h0000_0000, root: 32'h0000_0000, neg: 1'b0};
    tbl[4] = '{rad: 32'hFFFF_0000, root: 32'h0000_0000, neg: 1'b1};
    tbl[5] = '{rad: 32'h0009_0000, root: 32'h0003_0000, neg: 1'b0};
    tbl[6] = '{rad: 32'h0001_0000, root: 32'h0001_0000, neg: 1'b0};
    tbl[7] = '{rad: 32'h8000_0000, root: 32'h0000_0000, neg: 1'b1};
    tbl[8] = '{rad: 32'h0000_0001, root: 32'h0000_0100, neg: 1'b0};
    tbl[9] = '{rad: 32'h0019_0000, root: 32'h0005_0000, neg: 1'b0};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_rad   = '0;
    #2;
    chk("reset ready", W'(o_ready), W'(1));
    chk("reset valid", W'(o_valid), W'(0));
    chk("reset root", o_root, '0);
    chk("reset neg", W'(o_neg), W'(0));
    repeat (2) step();
    i_rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      xact(tbl[i].rad, tbl[i].root, tbl[i].neg, (i == 0) ? 10 : i % 3, 1'b0, i == 0 || i == 5,
           $sformatf("tbl%0d", i));
    end

    // Abort a computation with reset partway through RUN.
    i_valid = 1'b1;
    i_rad   = 32'h0004_0000;
    step();
    i_valid = 1'b0;
    repeat (12) step();
    chk("midrun busy", W'(o_ready), W'(0));
    #2 i_rst = 1'b1;
    #1;
    chk("abort valid", W'(o_valid), W'(0));
    chk("abort ready", W'(o_ready), W'(1));
    step();
    #2 i_rst = 1'b0;
    seen = 1'b0;
    repeat (R + 4) begin
      step();
      if (o_valid) seen = 1'b1;
    end
    chk("abort no_result", W'(seen), W'(0));
    xact(32'h0009_0000, 32'h0003_0000, 1'b0, 1, 1'b0, 1'b0, "post_abort");

    for (int i = 0; i < 40; i++) begin
      rad = $urandom;
      if ($urandom_range(3) != 0) rad[W-1] = 1'b0;
      if ($urandom_range(3) == 0) rad = rad >> $urandom_range(31);
      xact(rad, ref_root(rad), rad[W-1], $urandom_range(3), 1'($urandom), 1'($urandom),
           $sformatf("rnd%0d_%08h", i, rad));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
